// File: rtl/i2s_mask_pkg.sv
// Shared constants for the I2S row-addressed word extractor.
// Holds the header field positions and the receiver state encoding.
package i2s_mask_pkg;
    localparam int WORD_BITS   = 16;
    localparam int HDR_NX_MSB  = 15;
    localparam int HDR_NX_LSB  = 12;
    localparam int HDR_NY_MSB  = 11;
    localparam int HDR_NY_LSB  = 8;
    localparam int HDR_RSV_MSB = 7;
    localparam int HDR_RSV_LSB = 6;
    localparam int HDR_ROW_MSB = 5;
    localparam int HDR_ROW_LSB = 0;

    typedef enum logic {HEADER, DATA} state_t;
endpackage

// File: rtl/i2s_shift_rx.sv
// MSB-first serial deserialiser with a free-running bit counter.
// word/word_done are live on the edge sampling the LSB, so the consumer can register them with no extra latency.
module i2s_shift_rx #(
    parameter int WORD_BITS = 16
) (
    input  logic                 i2s_clk,
    input  logic                 rst_n,
    input  logic                 i2s_data,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_done
);
    localparam int BC_W = $clog2(WORD_BITS);

    // The first WORD_BITS-1 bits are stored; the LSB is the bit on the wire right now.
    logic [WORD_BITS-2:0] shreg;
    logic [BC_W-1:0]      bit_cnt;

    assign word      = {shreg, i2s_data};
    assign word_done = (bit_cnt == BC_W'(WORD_BITS - 1));

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= word[WORD_BITS-2:0];
            bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_mask.sv
// Row-addressed word extractor: parses a row header, then captures the one data word
// whose index matches this node's (module_x, module_y) position in the row.
module i2s_mask #(
    parameter int WORD_BITS = 16,
    parameter int CNT_BITS  = 4
) (
    input  logic                 rst_n,
    input  logic                 i2s_data,
    input  logic                 i2s_clk,
    input  logic [CNT_BITS-1:0]  module_x,
    input  logic [CNT_BITS-1:0]  module_y,
    output logic [5:0]           row_num,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 row_done,
    output logic                 error
);
    import i2s_mask_pkg::*;

    logic [WORD_BITS-1:0] word;
    logic                 word_done;

    i2s_shift_rx #(.WORD_BITS(WORD_BITS)) u_rx (
        .i2s_clk   (i2s_clk),
        .rst_n     (rst_n),
        .i2s_data  (i2s_data),
        .word      (word),
        .word_done (word_done)
    );

    state_t              state, state_nxt;
    logic [7:0]          word_cnt, word_cnt_nxt;
    logic [CNT_BITS-1:0] nx, ny;
    logic                in_range;
    logic                hdr_load, cap, last;

    logic [CNT_BITS-1:0] hdr_nx, hdr_ny;
    logic                hdr_out, hdr_rsv_bad;
    logic [7:0]          node_idx, last_idx;

    assign hdr_nx      = CNT_BITS'(word[HDR_NX_MSB:HDR_NX_LSB]);
    assign hdr_ny      = CNT_BITS'(word[HDR_NY_MSB:HDR_NY_LSB]);
    assign hdr_out     = (module_x > hdr_nx) || (module_y > hdr_ny);
    assign hdr_rsv_bad = (word[HDR_RSV_MSB:HDR_RSV_LSB] != 2'b00);

    // 8-bit modular arithmetic: a 16x16 row gives 256 words, last index 255.
    assign node_idx = 8'(module_y) * (8'(nx) + 8'd1) + 8'(module_x);
    assign last_idx = (8'(nx) + 8'd1) * (8'(ny) + 8'd1) - 8'd1;

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) state <= HEADER;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        hdr_load     = 1'b0;
        cap          = 1'b0;
        last         = 1'b0;
        case (state)
            HEADER: if (word_done) begin
                hdr_load     = 1'b1;
                word_cnt_nxt = '0;
                state_nxt    = DATA;
            end
            DATA: if (word_done) begin
                cap = in_range && (word_cnt == node_idx);
                if (word_cnt == last_idx) begin
                    last      = 1'b1;
                    state_nxt = HEADER;
                end else begin
                    word_cnt_nxt = word_cnt + 8'd1;
                end
            end
            default: state_nxt = HEADER;
        endcase
    end

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt   <= '0;
            nx         <= '0;
            ny         <= '0;
            in_range   <= 1'b0;
            row_num    <= '0;
            error      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            row_done   <= 1'b0;
        end else begin
            word_cnt   <= word_cnt_nxt;
            data_valid <= cap;
            row_done   <= last;
            if (hdr_load) begin
                nx       <= hdr_nx;
                ny       <= hdr_ny;
                in_range <= !hdr_out;
                row_num  <= word[HDR_ROW_MSB:HDR_ROW_LSB];
                error    <= hdr_out || hdr_rsv_bad;
            end
            if (cap) data_out <= word;
        end
    end
endmodule

// File: tb/tb_i2s_mask.sv
// 4x4 node array on one shared I2S stream; a row-level reference model queues the
// expected capture and row-end pulses and a negedge monitor checks every node.
module tb_i2s_mask;
    localparam int NN = 16;

    logic i2s_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic i2s_data = 1'b0;

    logic [5:0]  rn   [NN];
    logic [15:0] dout [NN];
    logic        dv   [NN];
    logic        rd   [NN];
    logic        er   [NN];

    for (genvar g = 0; g < NN; g++) begin : g_node
        i2s_mask #(.WORD_BITS(16), .CNT_BITS(4)) u_dut (
            .rst_n      (rst_n),
            .i2s_data   (i2s_data),
            .i2s_clk    (i2s_clk),
            .module_x   (4'(g % 4)),
            .module_y   (4'(g / 4)),
            .row_num    (rn[g]),
            .data_out   (dout[g]),
            .data_valid (dv[g]),
            .row_done   (rd[g]),
            .error      (er[g])
        );
    end

    always #5 i2s_clk = ~i2s_clk;

    int edge_cnt;
    always @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    int          q_dv_e [NN][$];
    logic [15:0] q_dv_d [NN][$];
    int          q_rd_e [NN][$];
    logic [5:0]  exp_rn   [NN];
    logic        exp_err  [NN];
    logic [15:0] exp_dout [NN];

    task automatic chk(input string nm, input int n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 60) $display("FAIL %s node %0d edge %0d: got %0h expected %0h", nm, n, edge_cnt, act, exp);
        end
    endtask

    task automatic flag(input string nm, input int n);
        n_chk++;
        n_fail++;
        if (n_fail < 60) $display("FAIL %s node %0d edge %0d", nm, n, edge_cnt);
    endtask

    always @(negedge i2s_clk) begin
        for (int n = 0; n < NN; n++) begin
            if (!rst_n) begin
                chk("reset_outputs", n, {dv[n], rd[n], er[n], rn[n], dout[n]}, 64'd0);
            end else begin
                chk("row_num", n, 64'(rn[n]), 64'(exp_rn[n]));
                chk("error", n, 64'(er[n]), 64'(exp_err[n]));
                if (q_dv_e[n].size() > 0 && q_dv_e[n][0] < edge_cnt) begin
                    flag("missed_data_valid", n);
                    void'(q_dv_e[n].pop_front());
                    exp_dout[n] = q_dv_d[n].pop_front();
                end
                if (dv[n]) begin
                    if (q_dv_e[n].size() == 0) flag("unexpected_data_valid", n);
                    else begin
                        chk("data_valid_edge", n, 64'(edge_cnt), 64'(q_dv_e[n].pop_front()));
                        exp_dout[n] = q_dv_d[n].pop_front();
                        chk("data_out_capture", n, 64'(dout[n]), 64'(exp_dout[n]));
                    end
                end
                chk("data_out_hold", n, 64'(dout[n]), 64'(exp_dout[n]));
                if (q_rd_e[n].size() > 0 && q_rd_e[n][0] < edge_cnt) begin
                    flag("missed_row_done", n);
                    void'(q_rd_e[n].pop_front());
                end
                if (rd[n]) begin
                    if (q_rd_e[n].size() == 0) flag("unexpected_row_done", n);
                    else chk("row_done_edge", n, 64'(edge_cnt), 64'(q_rd_e[n].pop_front()));
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        i2s_data = b;
        @(posedge i2s_clk);
        #1;
    endtask

    // Sends one row; stops after 'limit' bits when limit >= 0 (used to abort a row).
    task automatic send_row(input logic [15:0] hdr, input int limit);
        int nx, ny, nw, e0, sent, x, y;
        logic [15:0] w [256];
        logic [15:0] hv;
        nx = int'(hdr[15:12]);
        ny = int'(hdr[11:8]);
        nw = (nx + 1) * (ny + 1);
        e0 = edge_cnt;
        sent = 0;
        for (int k = 0; k < nw; k++) w[k] = 16'($urandom);
        for (int n = 0; n < NN; n++) begin
            x = n % 4;
            y = n / 4;
            if (x <= nx && y <= ny) begin
                q_dv_e[n].push_back(e0 + 16 + 16 * (y * (nx + 1) + x + 1));
                q_dv_d[n].push_back(w[y * (nx + 1) + x]);
            end
            q_rd_e[n].push_back(e0 + 16 + 16 * nw);
        end
        hv = hdr;
        for (int i = 15; i >= 0; i--) begin
            if (sent == limit) return;
            send_bit(hv[i]);
            sent++;
        end
        for (int n = 0; n < NN; n++) begin
            exp_rn[n]  = hdr[5:0];
            exp_err[n] = (n % 4 > nx) || (n / 4 > ny) || (hdr[7:6] != 2'b00);
        end
        for (int k = 0; k < nw; k++) begin
            hv = w[k];
            for (int i = 15; i >= 0; i--) begin
                if (sent == limit) return;
                send_bit(hv[i]);
                sent++;
            end
        end
    endtask

    task automatic flush_model();
        for (int n = 0; n < NN; n++) begin
            q_dv_e[n].delete();
            q_dv_d[n].delete();
            q_rd_e[n].delete();
            exp_rn[n]   = '0;
            exp_err[n]  = 1'b0;
            exp_dout[n] = '0;
        end
    endtask

    initial begin
        flush_model();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge i2s_clk);
        #2 rst_n = 1'b1;

        send_row(16'h3300, -1);
        send_row(16'h3305, -1);
        send_row(16'h1100, -1);
        send_row(16'h3340, -1);
        send_row(16'h0007, -1);
        send_row(16'h3300, -1);
        send_row(16'h3301, -1);
        send_row(16'h3300, 16 + 16 * 5 + 8);

        rst_n = 1'b0;
        flush_model();
        repeat (3) @(negedge i2s_clk);
        #2 rst_n = 1'b1;
        send_row(16'h3302, -1);

        repeat (2) @(negedge i2s_clk);
        #1;
        for (int n = 0; n < NN; n++) begin
            chk("pending_data_valid", n, 64'(q_dv_e[n].size()), 64'd0);
            chk("pending_row_done", n, 64'(q_rd_e[n].size()), 64'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_mask.md
I2S_MASK -- requirements
Module: i2s_mask

Interface
REQ-001 Parameter WORD_BITS, default 16: bits per header and per module data word.
REQ-002 Parameter CNT_BITS, default 4: width of each module-count field and each position input.
REQ-003 Port declaration order SHALL be: rst_n, i2s_data, i2s_clk, module_x, module_y, row_num, data_out, data_valid, row_done, error.
REQ-004 i2s_clk  input  1  sole clock; all sampling on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i2s_data  input  1  serial stream, MSB first.
REQ-007 module_x  input  4  this node's column, static.
REQ-008 module_y  input  4  this node's row position, static.
REQ-009 row_num  output  6  row number latched from the current header.
REQ-010 data_out  output  16  this node's most recently captured data word.
REQ-011 data_valid  output  1  one-cycle strobe when data_out updates.
REQ-012 row_done  output  1  one-cycle strobe after the last data word of a row.
REQ-013 error  output  1  sticky per-row flag for a bad header or an unaddressed node.

Function
REQ-014 Stream per row: one 16-bit header, then N = (NX+1)*(NY+1) 16-bit data words, with no gaps; rows follow back-to-back.
REQ-015 Header layout, MSB first: [15:12] NX = columns-1; [11:8] NY = rows-1; [7:6] reserved, must be 00; [5:0] row number.
REQ-016 FSM states: HEADER, DATA; a 4-bit bit counter and an 8-bit word counter.
REQ-017 HEADER: shift one bit per edge; on the 16th bit, latch NX, NY and row_num, evaluate error, clear the word counter, and go to DATA.
REQ-018 Node index = module_y*(NX+1) + module_x, computed at 8-bit width.
REQ-019 DATA: shift one bit per edge; on the 16th bit of word k, if k equals the node index and the node is in range, load data_out with the full word and pulse data_valid.
REQ-020 data_out and data_valid SHALL be registered by the edge that samples the word's LSB, with zero further latency.
REQ-021 On the LSB edge of word N-1: pulse row_done, return to HEADER, and reset the bit counter.
REQ-022 When the 16th header bit is sampled, error SHALL be 1 if module_x>NX or module_y>NY, or if the reserved bits are not 00; otherwise error SHALL be 0.
REQ-023 Out-of-range node: never pulses data_valid, but still counts words and pulses row_done.
REQ-024 Reserved-bits error alone: the row is still processed normally.
REQ-025 data_out holds its value across rows until the next match; row_num updates only at header completion.
REQ-026 NX=NY=0 (N=1): word 0 is also the last word, so data_valid and row_done pulse on the same edge.
REQ-027 If the clock stops mid-word, all state is held.

Reset
REQ-028 While rst_n=0: state=HEADER, all counters and shift register=0, row_num=0, data_out=0, data_valid=0, row_done=0, error=0.
REQ-029 Reset asserted mid-row aborts the row; the first bit after release is treated as header bit 15.

Structure
REQ-030 A shared package SHALL hold WORD_BITS, header field positions, and the state enum {HEADER, DATA}.
REQ-031 One sub-module, i2s_shift_rx, SHALL hold the 16-bit MSB-first shift register and bit counter and output a word_done strobe; i2s_mask contains the FSM, word counter and address match.

Verification
REQ-032 4x4 array of 16 instances, header 0x3300, then 256 random bits: each node (x,y) captures word 4y+x; node (1,2) pulses data_valid on rising edge 176 after release; all nodes pulse row_done on edge 272.
REQ-033 Header 0x3305: row_num=5 on all nodes from edge 16 onward; error=0.
REQ-034 Header 0x1100 to node (3,0): error=1, no data_valid over 4 words, row_done on edge 80.
REQ-035 Header 0x3340: error=1 on all nodes; data still captured correctly.
REQ-036 Two consecutive rows (0x3300, 0x3301) with distinct data: second header parsed with no gap; data_out updates per row.
REQ-037 Reset pulsed during word 5, then a fresh header 0x3302: all outputs 0 during reset; correct capture afterward.
